mash11_modulator: RTL

//  Sample-consuming end of the NCO AXI-stream sample path: accepts 16-bit unsigned samples
//  (m_axis_data side of the NCO) and noise-shapes them with a 2nd-order MASH 1-1 modulator.

---
 rtl/mash11_modulator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mash11_modulator.sv
// rtl/mash11_modulator.sv - 2nd-order MASH 1-1 modulator behind a one-entry AXI-stream sample buffer
// Optional feature: define MASH_DITHER_EN to add LFSR dither on the stage-1 carry-in.
module mash11_modulator #(
   parameter int WIDTH   = 16,
   parameter int OSR_DIV = 4
) (
   input  logic             aclk,
   input  logic             arst_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] s_axis_data_tdata,
   input  logic             s_axis_data_tvalid,
   output logic             s_axis_data_tready,
   output logic [1:0]       dac_code,
   output logic             dac_valid,
   output logic             underrun
);

   localparam int               CNT_W    = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR_DIV - 1);

   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             buf_full_q, buf_full_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] acc1_q, acc1_d;
   logic [WIDTH-1:0] acc2_q, acc2_d;
   logic             c2_dly_q, c2_dly_d;
   logic             tready_q, tready_d;
   logic [1:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             underrun_q, underrun_d;

   logic             tick;
   logic             accept;
   logic             cin;
   logic [WIDTH-1:0] x_eff;
   logic [WIDTH:0]   sum1;
   logic [WIDTH:0]   sum2;
   logic [2:0]       code_full;

   assign tick   = enable && (tick_cnt_q == CNT_LAST);
   assign accept = s_axis_data_tvalid && tready_q;
   assign x_eff  = buf_full_q ? buf_q : x_q;

   // Stage 2 integrates the stage-1 sum produced on this same tick.
   assign sum1 = {1'b0, acc1_q} + {1'b0, x_eff} + {{WIDTH{1'b0}}, cin};
   assign sum2 = {1'b0, acc2_q} + {1'b0, sum1[WIDTH-1:0]};

   // y + 1 = c1 + c2 - c2_dly + 1 lies in 0..3, so the 3-bit result never wraps.
   assign code_full = 3'd1 + {2'b00, sum1[WIDTH]} + {2'b00, sum2[WIDTH]} - {2'b00, c2_dly_q};

`ifdef MASH_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (tick) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
      end
   end

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign cin = lfsr_q[0];
`else
   assign cin = 1'b0;
`endif

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      x_d        = x_q;
      acc1_d     = acc1_q;
      acc2_d     = acc2_q;
      c2_dly_d   = c2_dly_q;
      code_d     = code_q;
      valid_d    = 1'b0;
      underrun_d = 1'b0;

      if (!enable || tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end

      if (tick) begin
         x_d        = x_eff;
         buf_full_d = 1'b0;
         acc1_d     = sum1[WIDTH-1:0];
         acc2_d     = sum2[WIDTH-1:0];
         c2_dly_d   = sum2[WIDTH];
         code_d     = code_full[1:0];
         valid_d    = 1'b1;
         underrun_d = !buf_full_q;
      end

      // accept only happens while the buffer is empty, so it never races the tick unload
      if (accept) begin
         buf_d      = s_axis_data_tdata;
         buf_full_d = 1'b1;
      end
   end

   // tready is its own flop so it reads 0 while reset is held and 1 only after release.
   assign tready_d = !buf_full_d;

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         tick_cnt_q <= '0;
         buf_full_q <= 1'b0;
         buf_q      <= '0;
         x_q        <= '0;
         acc1_q     <= '0;
         acc2_q     <= '0;
         c2_dly_q   <= 1'b0;
         tready_q   <= 1'b0;
         code_q     <= 2'd1;
         valid_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         buf_full_q <= buf_full_d;
         buf_q      <= buf_d;
         x_q        <= x_d;
         acc1_q     <= acc1_d;
         acc2_q     <= acc2_d;
         c2_dly_q   <= c2_dly_d;
         tready_q   <= tready_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         underrun_q <= underrun_d;
      end
   end

   assign s_axis_data_tready = tready_q;
   assign dac_code           = code_q;
   assign dac_valid          = valid_q;
   assign underrun           = underrun_q;

endmodule
